// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types and constants for the sleep controller
// Contents:
//   sleep_ctrl_state_e : sleep controller FSM state, encoding visible on state_o
//   SLEEP_WAKE_CNT_W   : width of the wake-delay down-counter
package cv32e40p_pkg;

    localparam int unsigned SLEEP_WAKE_CNT_W = 4;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SLEEP  = 2'd2,
        WAKE   = 2'd3
    } sleep_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_sleep_stats.sv
// rtl/cv32e40p_sleep_stats.sv - saturating 32-bit sleep cycle counter
// Ports:
//   clk_i    : free-running clock
//   rst_ni   : asynchronous active-low reset
//   clear_i  : synchronous clear, wins over increment
//   inc_i    : count this cycle
//   count_o  : current count, holds at 32'hFFFF_FFFF
module cv32e40p_sleep_stats (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] cnt_d;
    logic [31:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/cv32e40p_sleep_ctrl.sv
// rtl/cv32e40p_sleep_ctrl.sv - WFI sleep sequencer for the core clock gate
// Optional feature macro: CV32E40P_SLEEP_STATS_EN (sleep cycle statistics).
// Parameter WAKE_CYCLES (1..15): cycles spent in WAKE before WFI retires.
// Ports:
//   clk_ungated_i  : free-running clock
//   rst_n          : asynchronous active-low reset
//   setback_i      : synchronous return to reset state
//   fetch_enable_i : fetch enable, made sticky here
//   wfi_req_i      : WFI held in ID
//   no_sleep_i     : debug / single-step / trigger, WFI must not sleep
//   irq_pending_i  : enabled interrupt pending
//   debug_req_i    : external debug request
//   if/lsu/apu_busy_i : outstanding activity that must drain before sleep
//   fetch_enable_o : sticky fetch enable
//   clock_en_o     : enable to the core clock gate
//   core_sleep_o   : core is asleep
//   wfi_done_o     : one-cycle pulse, WFI may retire
//   state_o        : FSM state for trace
//   sleep_cycles_o : sleep cycle count (zero without the stats macro)
module cv32e40p_sleep_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk_ungated_i,
    input  logic        rst_n,
    input  logic        setback_i,
    input  logic        fetch_enable_i,
    input  logic        wfi_req_i,
    input  logic        no_sleep_i,
    input  logic        irq_pending_i,
    input  logic        debug_req_i,
    input  logic        if_busy_i,
    input  logic        lsu_busy_i,
    input  logic        apu_busy_i,
    output logic        fetch_enable_o,
    output logic        clock_en_o,
    output logic        core_sleep_o,
    output logic        wfi_done_o,
    output logic [1:0]  state_o,
    output logic [31:0] sleep_cycles_o
);

    if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 15)) begin : g_bad_wake_cycles
        $error("cv32e40p_sleep_ctrl: WAKE_CYCLES must be in 1..15");
    end

    localparam logic [SLEEP_WAKE_CNT_W-1:0] WAKE_LOAD = SLEEP_WAKE_CNT_W'(WAKE_CYCLES - 1);

    sleep_ctrl_state_e             state_d, state_q;
    logic [SLEEP_WAKE_CNT_W-1:0]   cnt_d, cnt_q;
    logic                          fetch_enable_d, fetch_enable_q;
    logic                          wake_evt;
    logic                          busy;

    assign wake_evt = irq_pending_i | debug_req_i;
    assign busy     = if_busy_i | lsu_busy_i | apu_busy_i;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fetch_enable_d = fetch_enable_q | fetch_enable_i;
        clock_en_o     = 1'b0;
        core_sleep_o   = 1'b0;
        wfi_done_o     = 1'b0;

        unique case (state_q)
            ACTIVE: begin
                clock_en_o = fetch_enable_q;
                if (fetch_enable_q && wfi_req_i) begin
                    // A WFI that cannot sleep retires immediately as a NOP.
                    if (no_sleep_i || wake_evt) begin
                        wfi_done_o = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                clock_en_o = 1'b1;
                if (!wfi_req_i) begin
                    state_d = ACTIVE;
                end else if (wake_evt) begin
                    state_d = WAKE;
                    cnt_d   = WAKE_LOAD;
                end else if (!busy) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                // Combinational so the gated clock restarts in the wake cycle;
                // nothing else registered changes while asleep.
                clock_en_o   = wake_evt;
                core_sleep_o = !wake_evt;
                if (wake_evt) begin
                    state_d = WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            WAKE: begin
                clock_en_o = 1'b1;
                if (cnt_q == '0) begin
                    wfi_done_o = 1'b1;
                    state_d    = ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase

        if (setback_i) begin
            state_d        = ACTIVE;
            cnt_d          = '0;
            fetch_enable_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACTIVE;
            cnt_q          <= '0;
            fetch_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fetch_enable_q <= fetch_enable_d;
        end
    end

    assign fetch_enable_o = fetch_enable_q;
    assign state_o        = state_q;

`ifdef CV32E40P_SLEEP_STATS_EN
    cv32e40p_sleep_stats u_stats (
        .clk_i   (clk_ungated_i),
        .rst_ni  (rst_n),
        .clear_i (setback_i),
        .inc_i   (core_sleep_o),
        .count_o (sleep_cycles_o)
    );
`else
    assign sleep_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// tb/tb_cv32e40p_sleep_ctrl.sv - self-checking bench for cv32e40p_sleep_ctrl
module tb_cv32e40p_sleep_ctrl;

    localparam int WC = 2;
`ifdef CV32E40P_SLEEP_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
    localparam int M_RUN = 0, M_DRAIN = 1, M_ASLEEP = 2, M_WAKING = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic setback = 1'b0;
    logic fe_i = 1'b0;
    logic wfi = 1'b0;
    logic no_sleep = 1'b0;
    logic irq = 1'b0;
    logic dbg = 1'b0;
    logic if_busy = 1'b0;
    logic lsu_busy = 1'b0;
    logic apu_busy = 1'b0;
    logic        fe_o, clk_en, core_sleep, wfi_done;
    logic [1:0]  state;
    logic [31:0] sleep_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cv32e40p_sleep_ctrl #(.WAKE_CYCLES(WC)) dut (
        .clk_ungated_i  (clk),
        .rst_n          (rst_n),
        .setback_i      (setback),
        .fetch_enable_i (fe_i),
        .wfi_req_i      (wfi),
        .no_sleep_i     (no_sleep),
        .irq_pending_i  (irq),
        .debug_req_i    (dbg),
        .if_busy_i      (if_busy),
        .lsu_busy_i     (lsu_busy),
        .apu_busy_i     (apu_busy),
        .fetch_enable_o (fe_o),
        .clock_en_o     (clk_en),
        .core_sleep_o   (core_sleep),
        .wfi_done_o     (wfi_done),
        .state_o        (state),
        .sleep_cycles_o (sleep_cycles)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // From SLEEP: raise irq for one cycle, ride out WAKE, land in ACTIVE with wfi dropped.
    task automatic wake_out();
        irq = 1'b1;
        next_cycle();
        irq = 1'b0;
        repeat (WC) next_cycle();
        wfi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fe_i  = 1'b1;
        wfi   = 1'b1;
        repeat (2) next_cycle();
        checks++;
        if ({fe_o, clk_en, core_sleep, wfi_done, state} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", {fe_o, clk_en, core_sleep, wfi_done, state}, 6'b0);
        end
        checks++;
        if (sleep_cycles !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: got %h want %h", sleep_cycles, 32'h0);
        end
        fe_i = 1'b0;
        wfi  = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_enable();
        for (int c = 0; c <= 8; c++) begin
            fe_i = (c == 5);
            settle();
            checks++;
            if ({fe_o, clk_en, state} !== {(c >= 6), (c >= 6), 2'd0}) begin
                errors++;
                $display("FAIL fetch_enable c=%0d: got %b want %b", c, {fe_o, clk_en, state}, {(c >= 6), (c >= 6), 2'd0});
            end
            next_cycle();
        end
    endtask

    task automatic test_sleep_wake();
        logic [31:0] exp_sc;
        wfi = 1'b1;
        settle();
        checks++;
        if ({fe_o, clk_en, core_sleep, wfi_done, state} !== 6'b110000) begin
            errors++;
            $display("FAIL sw_active: got %b want %b", {fe_o, clk_en, core_sleep, wfi_done, state}, 6'b110000);
        end
        next_cycle();
        checks++;
        if ({fe_o, clk_en, core_sleep, wfi_done, state} !== 6'b110001) begin
            errors++;
            $display("FAIL sw_drain: got %b want %b", {fe_o, clk_en, core_sleep, wfi_done, state}, 6'b110001);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if ({fe_o, clk_en, core_sleep, wfi_done, state} !== 6'b101010) begin
                errors++;
                $display("FAIL sw_sleep k=%0d: got %b want %b", k, {fe_o, clk_en, core_sleep, wfi_done, state}, 6'b101010);
            end
            exp_sc = STATS_EN ? 32'(k) : 32'h0;
            checks++;
            if (sleep_cycles !== exp_sc) begin
                errors++;
                $display("FAIL sw_stats k=%0d: got %0d want %0d", k, sleep_cycles, exp_sc);
            end
            next_cycle();
        end
        irq = 1'b1;
        settle();
        checks++;
        if ({fe_o, clk_en, core_sleep, wfi_done, state} !== 6'b110010) begin
            errors++;
            $display("FAIL sw_irq_cycle: got %b want %b", {fe_o, clk_en, core_sleep, wfi_done, state}, 6'b110010);
        end
        next_cycle();
        irq = 1'b0;
        for (int k = 1; k <= WC; k++) begin
            settle();
            checks++;
            if ({clk_en, core_sleep, wfi_done, state} !== {1'b1, 1'b0, (k == WC), 2'd3}) begin
                errors++;
                $display("FAIL sw_wake k=%0d: got %b want %b", k, {clk_en, core_sleep, wfi_done, state}, {1'b1, 1'b0, (k == WC), 2'd3});
            end
            next_cycle();
        end
        wfi = 1'b0;
        settle();
        checks++;
        if ({clk_en, core_sleep, wfi_done, state} !== 5'b10000) begin
            errors++;
            $display("FAIL sw_back_active: got %b want %b", {clk_en, core_sleep, wfi_done, state}, 5'b10000);
        end
        next_cycle();
    endtask

    task automatic test_drain_busy();
        logic [1:0] exp_st;
        logic       exp_done;
        for (int c = 0; c <= 5; c++) begin
            wfi      = 1'b1;
            lsu_busy = (c < 4);
            settle();
            exp_st = (c == 0) ? 2'd0 : ((c <= 4) ? 2'd1 : 2'd2);
            checks++;
            if ({state, core_sleep} !== {exp_st, (c == 5)}) begin
                errors++;
                $display("FAIL drain_busy c=%0d: got %b want %b", c, {state, core_sleep}, {exp_st, (c == 5)});
            end
            next_cycle();
        end
        wake_out();
        lsu_busy = 1'b1;
        for (int c = 0; c <= WC + 3; c++) begin
            dbg = (c == 2);
            wfi = (c <= 2 + WC);
            settle();
            exp_st   = (c == 0) ? 2'd0 : (c <= 2) ? 2'd1 : (c <= 2 + WC) ? 2'd3 : 2'd0;
            exp_done = (c == 2 + WC);
            checks++;
            if ({state, core_sleep, wfi_done} !== {exp_st, 1'b0, exp_done}) begin
                errors++;
                $display("FAIL drain_debug c=%0d: got %b want %b", c, {state, core_sleep, wfi_done}, {exp_st, 1'b0, exp_done});
            end
            next_cycle();
        end
        lsu_busy = 1'b0;
        dbg = 1'b0;
    endtask

    task automatic test_nop();
        for (int v = 0; v < 2; v++) begin
            wfi      = 1'b1;
            no_sleep = (v == 0);
            irq      = (v == 1);
            settle();
            checks++;
            if ({clk_en, wfi_done, state} !== 4'b1100) begin
                errors++;
                $display("FAIL nop_pulse v=%0d: got %b want %b", v, {clk_en, wfi_done, state}, 4'b1100);
            end
            next_cycle();
            wfi = 1'b0;
            no_sleep = 1'b0;
            irq = 1'b0;
            settle();
            checks++;
            if ({clk_en, wfi_done, state} !== 4'b1000) begin
                errors++;
                $display("FAIL nop_after v=%0d: got %b want %b", v, {clk_en, wfi_done, state}, 4'b1000);
            end
            next_cycle();
        end
    endtask

    task automatic test_setback();
        wfi = 1'b1;
        next_cycle();
        next_cycle();
        setback = 1'b1;
        settle();
        checks++;
        if ({core_sleep, state} !== 3'b110) begin
            errors++;
            $display("FAIL setback_sleeping: got %b want %b", {core_sleep, state}, 3'b110);
        end
        next_cycle();
        setback = 1'b0;
        settle();
        checks++;
        if ({fe_o, clk_en, core_sleep, wfi_done, state} !== 6'b0) begin
            errors++;
            $display("FAIL setback_after: got %b want %b", {fe_o, clk_en, core_sleep, wfi_done, state}, 6'b0);
        end
        next_cycle();
        checks++;
        if ({wfi_done, state} !== 3'b000) begin
            errors++;
            $display("FAIL setback_wfi_ignored: got %b want %b", {wfi_done, state}, 3'b000);
        end
        wfi  = 1'b0;
        fe_i = 1'b1;
        next_cycle();
        fe_i = 1'b0;
        settle();
        checks++;
        if ({fe_o, clk_en} !== 2'b11) begin
            errors++;
            $display("FAIL setback_refetch: got %b want %b", {fe_o, clk_en}, 2'b11);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        wfi = 1'b1;
        next_cycle();
        next_cycle();
        irq = 1'b1;
        next_cycle();
        irq = 1'b0;
        settle();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL async_mid_wake: got %0d want %0d", state, 3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fe_o, clk_en, core_sleep, wfi_done, state, sleep_cycles} !== 38'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", {fe_o, clk_en, core_sleep, wfi_done, state, sleep_cycles}, 38'b0);
        end
        wfi = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        fe_i = 1'b1;
        next_cycle();
        fe_i = 1'b0;
    endtask

    task automatic test_stats();
        logic [31:0] exp_sc;
        setback = 1'b1;
        next_cycle();
        setback = 1'b0;
        fe_i = 1'b1;
        next_cycle();
        fe_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wfi = 1'b1;
            next_cycle();
            next_cycle();
            repeat (10) next_cycle();
            wake_out();
        end
        settle();
        exp_sc = STATS_EN ? 32'd20 : 32'd0;
        checks++;
        if (sleep_cycles !== exp_sc) begin
            errors++;
            $display("FAIL stats_twenty: got %0d want %0d", sleep_cycles, exp_sc);
        end
        next_cycle();
`ifdef CV32E40P_SLEEP_STATS_EN
        dut.u_stats.cnt_q = 32'hFFFF_FFFD;
        wfi = 1'b1;
        next_cycle();
        next_cycle();
        repeat (5) next_cycle();
        settle();
        checks++;
        if (sleep_cycles !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stats_saturate: got %h want %h", sleep_cycles, 32'hFFFF_FFFF);
        end
        wake_out();
        next_cycle();
`endif
    endtask

    // Reference: sleep permission and wake latency expressed as cycle arithmetic.
    task automatic test_random();
        int          mode, nxt, wake_at;
        bit          m_fe, e_clk, e_sleep, e_done, wake_e, busy_e;
        logic [31:0] m_stats, exp_sc;
        rst_n = 1'b0;
        {setback, fe_i, wfi, no_sleep, irq, dbg, if_busy, lsu_busy, apu_busy} = '0;
        next_cycle();
        rst_n = 1'b1;
        mode = M_RUN;
        m_fe = 1'b0;
        m_stats = '0;
        wake_at = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(7) == 0) wfi = ~wfi;
            if_busy  = ($urandom_range(5) == 0);
            lsu_busy = ($urandom_range(3) == 0);
            apu_busy = ($urandom_range(7) == 0);
            irq      = ($urandom_range(9) == 0);
            dbg      = ($urandom_range(19) == 0);
            no_sleep = ($urandom_range(9) == 0);
            setback  = ($urandom_range(99) == 0);
            fe_i     = ($urandom_range(4) == 0);
            settle();
            wake_e  = irq | dbg;
            busy_e  = if_busy | lsu_busy | apu_busy;
            e_done  = 1'b0;
            e_sleep = 1'b0;
            nxt     = mode;
            if (mode == M_RUN) begin
                e_clk = m_fe;
                if (m_fe && wfi) begin
                    if (no_sleep || wake_e) e_done = 1'b1;
                    else nxt = M_DRAIN;
                end
            end else if (mode == M_DRAIN) begin
                e_clk = 1'b1;
                if (!wfi) nxt = M_RUN;
                else if (wake_e) begin nxt = M_WAKING; wake_at = cyc + WC; end
                else if (!busy_e) nxt = M_ASLEEP;
            end else if (mode == M_ASLEEP) begin
                e_clk   = wake_e;
                e_sleep = !wake_e;
                if (wake_e) begin nxt = M_WAKING; wake_at = cyc + WC; end
            end else begin
                e_clk = 1'b1;
                if (cyc == wake_at) begin e_done = 1'b1; nxt = M_RUN; end
            end
            checks++;
            if ({fe_o, clk_en, core_sleep, wfi_done, state} !== {m_fe, e_clk, e_sleep, e_done, 2'(mode)}) begin
                errors++;
                $display("FAIL random cyc=%0d: got %b want %b", cyc, {fe_o, clk_en, core_sleep, wfi_done, state}, {m_fe, e_clk, e_sleep, e_done, 2'(mode)});
            end
            exp_sc = STATS_EN ? m_stats : 32'h0;
            checks++;
            if (sleep_cycles !== exp_sc) begin
                errors++;
                $display("FAIL random_stats cyc=%0d: got %0d want %0d", cyc, sleep_cycles, exp_sc);
            end
            if (e_sleep && (m_stats != 32'hFFFF_FFFF)) m_stats = m_stats + 1;
            m_fe = m_fe | fe_i;
            mode = nxt;
            if (setback) begin
                mode = M_RUN;
                m_fe = 1'b0;
                m_stats = '0;
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_enable();
        test_sleep_wake();
        test_drain_busy();
        test_nop();
        test_setback();
        test_async_reset();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
